pipeline_hazard_controller: RTL and testbench

Central hazard and sequencing controller for the 5-stage core. It watches the instructions in ID and EX, the EX-stage branch/jump resolution, a multi-cycle multiply/divide unit (MDU) and the data-memory ready signal. From these it drives PC redirect plus per-stage stall/flush/bubble controls for the PC, IF/ID, ID/EX and EX/MEM registers. It owns the only state machine that holds the pipeline across multiple cycles.

---
 rtl/pipeline_hazard_controller_if.sv | 42 ++++
 rtl/pipeline_hazard_controller.sv | 116 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard controller port bundle: ID/EX observation, MDU and memory handshakes in,
// per-stage stall/flush/redirect controls out.
interface pipeline_hazard_controller_if;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_rs1_valid;
    logic        id_rs2_valid;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_rd_addr;
    logic        ex_mdu_op;
    logic        ex_jump_signal;
    logic [31:0] ex_jump_addr;
    logic        mdu_done;
    logic        mem_stall;
    logic        pc_redirect;
    logic [31:0] pc_redirect_addr;
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_bubble;
    logic        mdu_start;
    logic        mdu_error;
    logic        busy;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_valid, id_rs2_valid,
               ex_opcode, ex_rd_addr, ex_mdu_op, ex_jump_signal, ex_jump_addr,
               mdu_done, mem_stall,
        input  pc_redirect, pc_redirect_addr, pc_stall, if_id_stall, id_ex_stall,
               if_id_flush, id_ex_flush, ex_mem_bubble, mdu_start, mdu_error, busy
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_valid, id_rs2_valid,
               ex_opcode, ex_rd_addr, ex_mdu_op, ex_jump_signal, ex_jump_addr,
               mdu_done, mem_stall,
        output pc_redirect, pc_redirect_addr, pc_stall, if_id_stall, id_ex_stall,
               if_id_flush, id_ex_flush, ex_mem_bubble, mdu_start, mdu_error, busy
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// 5-stage core hazard controller: load-use bubbles, EX branch redirect, memory
// freeze and the RUN/MDU_WAIT sequencer that holds the pipe during multi-cycle MDU ops.
module pipeline_hazard_controller #(
    parameter int MDU_TIMEOUT = 64
) (
    input logic clk,
    input logic rst,
    pipeline_hazard_controller_if.slave hz
);
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [7:0] CNT_MAX = 8'hff;
    localparam logic [7:0] CNT_TO  = 8'(MDU_TIMEOUT - 1);

    typedef enum logic {RUN, MDU_WAIT} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       done_seen;
    logic       err_q;

    logic load_use;
    logic timed_out;
    logic got_done;
    logic rel;

    assign load_use = (hz.ex_opcode == OP_LOAD) && (hz.ex_rd_addr != 5'd0) &&
                      ((hz.id_rs1_valid && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                       (hz.id_rs2_valid && (hz.id_rs2_addr == hz.ex_rd_addr)));

    // >= so a mem_stall spanning the timeout cycle cannot leave the wait stuck
    assign timed_out = (cnt >= CNT_TO);
    assign got_done  = hz.mdu_done || done_seen;
    assign rel       = (got_done || timed_out) && !hz.mem_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= 8'd0;
            done_seen <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!hz.mem_stall && !hz.ex_jump_signal && hz.ex_mdu_op) begin
                        state     <= MDU_WAIT;
                        cnt       <= 8'd0;
                        done_seen <= 1'b0;
                    end
                end
                MDU_WAIT: begin
                    if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
                    if (rel) begin
                        state     <= RUN;
                        done_seen <= 1'b0;
                        if (!got_done) err_q <= 1'b1;
                    end else if (hz.mdu_done) begin
                        done_seen <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        hz.pc_redirect      = 1'b0;
        hz.pc_redirect_addr = 32'd0;
        hz.pc_stall         = 1'b0;
        hz.if_id_stall      = 1'b0;
        hz.id_ex_stall      = 1'b0;
        hz.if_id_flush      = 1'b0;
        hz.id_ex_flush      = 1'b0;
        hz.ex_mem_bubble    = 1'b0;
        hz.mdu_start        = 1'b0;
        hz.mdu_error        = 1'b0;
        hz.busy             = 1'b0;
        if (!rst) begin
            hz.mdu_error = err_q;
            hz.busy      = (state == MDU_WAIT);
            case (state)
                RUN: begin
                    if (hz.mem_stall) begin
                        // EX/MEM freezes through its own mem_stall enable
                        hz.pc_stall    = 1'b1;
                        hz.if_id_stall = 1'b1;
                        hz.id_ex_stall = 1'b1;
                    end else if (hz.ex_jump_signal) begin
                        hz.pc_redirect      = 1'b1;
                        hz.pc_redirect_addr = hz.ex_jump_addr;
                        hz.if_id_flush      = 1'b1;
                        hz.id_ex_flush      = 1'b1;
                    end else if (hz.ex_mdu_op) begin
                        hz.mdu_start     = 1'b1;
                        hz.pc_stall      = 1'b1;
                        hz.if_id_stall   = 1'b1;
                        hz.id_ex_stall   = 1'b1;
                        hz.ex_mem_bubble = 1'b1;
                    end else if (load_use) begin
                        hz.pc_stall    = 1'b1;
                        hz.if_id_stall = 1'b1;
                        hz.id_ex_flush = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (!rel) begin
                        hz.pc_stall      = 1'b1;
                        hz.if_id_stall   = 1'b1;
                        hz.id_ex_stall   = 1'b1;
                        hz.ex_mem_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: RUN-state vector table plus
// hand-written MDU, timeout and reset sequences (MDU_TIMEOUT=4).
module tb_pipeline_hazard_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if hz ();

    pipeline_hazard_controller #(.MDU_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    // output order: redirect, pc_st, ifid_st, idex_st, ifid_fl, idex_fl, bubble, start, busy, err
    typedef logic [9:0] outs_t;

    typedef struct {
        string       name;
        logic [4:0]  rs1, rs2;
        logic        v1, v2;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic        mdu_op, jmp;
        logic [31:0] jaddr;
        logic        done, mstall;
        outs_t       exp;
        logic [31:0] exp_addr;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl[11];

    function automatic outs_t dut_outs();
        return {hz.pc_redirect, hz.pc_stall, hz.if_id_stall, hz.id_ex_stall,
                hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_bubble, hz.mdu_start,
                hz.busy, hz.mdu_error};
    endfunction

    task automatic idle_inputs();
        hz.id_rs1_addr = 5'd0; hz.id_rs2_addr = 5'd0;
        hz.id_rs1_valid = 1'b0; hz.id_rs2_valid = 1'b0;
        hz.ex_opcode = 7'b0010011; hz.ex_rd_addr = 5'd0;
        hz.ex_mdu_op = 1'b0; hz.ex_jump_signal = 1'b0; hz.ex_jump_addr = 32'd0;
        hz.mdu_done = 1'b0; hz.mem_stall = 1'b0;
    endtask

    // compare at negedge, then advance to just after the next rising edge
    task automatic chk(input string name, input outs_t exp, input logic [31:0] exp_addr);
        outs_t act;
        @(negedge clk);
        act = dut_outs();
        checks++;
        if (act !== exp || hz.pc_redirect_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s: got outs=%b addr=%h, expected outs=%b addr=%h",
                     name, act, hz.pc_redirect_addr, exp, exp_addr);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          name       rs1 rs2 v1 v2 opcode       rd  mdu jmp addr          dn ms  exp            addr
        tbl[0]  = '{"idle",    0,  0,  0, 0, 7'b0010011, 0,  0,  0,  32'h0,        0, 0, 10'b0000000000, 32'h0};
        tbl[1]  = '{"lu_rs1",  5,  1,  1, 1, 7'b0000011, 5,  0,  0,  32'h0,        0, 0, 10'b0110010000, 32'h0};
        tbl[2]  = '{"lu_rd0",  0,  1,  1, 1, 7'b0000011, 0,  0,  0,  32'h0,        0, 0, 10'b0000000000, 32'h0};
        tbl[3]  = '{"lu_rs2",  1,  7,  1, 1, 7'b0000011, 7,  0,  0,  32'h0,        0, 0, 10'b0110010000, 32'h0};
        tbl[4]  = '{"lu_v2_0", 1,  7,  1, 0, 7'b0000011, 7,  0,  0,  32'h0,        0, 0, 10'b0000000000, 32'h0};
        tbl[5]  = '{"noload",  5,  1,  1, 1, 7'b0110011, 5,  0,  0,  32'h0,        0, 0, 10'b0000000000, 32'h0};
        tbl[6]  = '{"br_lu",   5,  1,  1, 1, 7'b0000011, 5,  0,  1,  32'h100,      0, 0, 10'b1000110000, 32'h100};
        tbl[7]  = '{"ms_br",   5,  1,  1, 1, 7'b0000011, 5,  0,  1,  32'h100,      0, 1, 10'b0111000000, 32'h0};
        tbl[8]  = '{"ms_mdu",  0,  0,  0, 0, 7'b0110011, 3,  1,  0,  32'h0,        0, 1, 10'b0111000000, 32'h0};
        tbl[9]  = '{"spur_dn", 0,  0,  0, 0, 7'b0010011, 0,  0,  0,  32'h0,        1, 0, 10'b0000000000, 32'h0};
        tbl[10] = '{"br_mdu",  0,  0,  0, 0, 7'b0110011, 3,  1,  1,  32'hdeadbeef, 0, 0, 10'b1000110000, 32'hdeadbeef};

        idle_inputs();
        #1;
        chk("reset", 10'b0000000000, 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            hz.id_rs1_addr = tbl[i].rs1; hz.id_rs2_addr = tbl[i].rs2;
            hz.id_rs1_valid = tbl[i].v1; hz.id_rs2_valid = tbl[i].v2;
            hz.ex_opcode = tbl[i].opc; hz.ex_rd_addr = tbl[i].rd;
            hz.ex_mdu_op = tbl[i].mdu_op; hz.ex_jump_signal = tbl[i].jmp;
            hz.ex_jump_addr = tbl[i].jaddr; hz.mdu_done = tbl[i].done;
            hz.mem_stall = tbl[i].mstall;
            chk(tbl[i].name, tbl[i].exp, tbl[i].exp_addr);
        end
        idle_inputs();
        chk("post_tbl", 10'b0000000000, 32'h0);

        // MDU normal: done 3 cycles after start; a branch during the wait is ignored
        hz.ex_mdu_op = 1'b1;
        chk("mdu_start", 10'b0111001100, 32'h0);
        hz.ex_mdu_op = 1'b0;
        chk("mdu_w1", 10'b0111001010, 32'h0);
        hz.ex_jump_signal = 1'b1; hz.ex_jump_addr = 32'h200;
        chk("mdu_w2_br", 10'b0111001010, 32'h0);
        hz.ex_jump_signal = 1'b0; hz.mdu_done = 1'b1;
        chk("mdu_rel", 10'b0000000010, 32'h0);
        hz.mdu_done = 1'b0;
        chk("mdu_after", 10'b0000000000, 32'h0);

        // done while mem_stall, release once mem_stall drops
        hz.ex_mdu_op = 1'b1;
        chk("ms_start", 10'b0111001100, 32'h0);
        hz.ex_mdu_op = 1'b0; hz.mdu_done = 1'b1; hz.mem_stall = 1'b1;
        chk("ms_done", 10'b0111001010, 32'h0);
        hz.mdu_done = 1'b0;
        chk("ms_hold", 10'b0111001010, 32'h0);
        hz.mem_stall = 1'b0;
        chk("ms_rel", 10'b0000000010, 32'h0);
        chk("ms_after", 10'b0000000000, 32'h0);

        // timeout without done: release at cnt=3, sticky error
        hz.ex_mdu_op = 1'b1;
        chk("to_start", 10'b0111001100, 32'h0);
        hz.ex_mdu_op = 1'b0;
        for (int c = 0; c < 3; c++) chk($sformatf("to_wait%0d", c), 10'b0111001010, 32'h0);
        chk("to_rel", 10'b0000000010, 32'h0);
        chk("to_err", 10'b0000000001, 32'h0);
        hz.ex_mdu_op = 1'b1;
        chk("to2_start", 10'b0111001101, 32'h0);
        hz.ex_mdu_op = 1'b0; hz.mdu_done = 1'b1;
        chk("to2_rel", 10'b0000000011, 32'h0);
        hz.mdu_done = 1'b0;
        chk("to2_sticky", 10'b0000000001, 32'h0);

        // reset mid-wait clears state and error
        hz.ex_mdu_op = 1'b1;
        chk("rw_start", 10'b0111001101, 32'h0);
        hz.ex_mdu_op = 1'b0;
        chk("rw_wait", 10'b0111001011, 32'h0);
        rst = 1'b1;
        chk("rw_rst", 10'b0000000000, 32'h0);
        rst = 1'b0;
        chk("rw_after", 10'b0000000000, 32'h0);

        // done coincident with timeout: normal release, no error
        hz.ex_mdu_op = 1'b1;
        chk("dt_start", 10'b0111001100, 32'h0);
        hz.ex_mdu_op = 1'b0;
        for (int c = 0; c < 3; c++) chk($sformatf("dt_wait%0d", c), 10'b0111001010, 32'h0);
        hz.mdu_done = 1'b1;
        chk("dt_rel", 10'b0000000010, 32'h0);
        hz.mdu_done = 1'b0;
        chk("dt_noerr", 10'b0000000000, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
